fifo_axis_downsizer: RTL and testbench



---
 rtl/fifo_axis_downsizer.sv | 145 ++++++++++++++
 tb/tb_fifo_axis_downsizer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_downsizer.sv
// ---------------------------------------------------------------------------
// fifo_axis_downsizer
//
// AXI-Stream width downsizer placed directly after the wide stream FIFO.
// Each accepted IN_W-bit beat is held in a buffer and replayed as
// RATIO = IN_W/OUT_W consecutive OUT_W-bit slices. The final slice of the
// buffered beat may be drained on the same edge that loads the next beat,
// so a continuously fed consumer sees one slice every cycle.
//
// Parameters:
//   IN_W      input beat width (multiple of OUT_W)
//   OUT_W     output slice width
//   HAS_LAST  "true" carries axis_last_i to the final slice, "false" ties
//             axis_last_o low
//   MSB_FIRST "true" emits the top slice first, "false" emits bits
//             OUT_W-1:0 first
//
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   axis_data_i   wide input beat
//   axis_valid_i  input beat valid
//   axis_last_i   input beat ends a packet
//   axis_ready_o  downsizer accepts a beat this cycle
//   axis_data_o   current narrow slice (zero when axis_valid_o is low)
//   axis_valid_o  slice valid
//   axis_last_o   final slice of a last-flagged beat
//   axis_ready_i  consumer accepts the slice
// ---------------------------------------------------------------------------
module fifo_axis_downsizer #(
    parameter int    IN_W      = 512,
    parameter int    OUT_W     = 64,
    parameter string HAS_LAST  = "false",
    parameter string MSB_FIRST = "false"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  axis_data_i,
    input  logic             axis_valid_i,
    input  logic             axis_last_i,
    output logic             axis_ready_o,
    output logic [OUT_W-1:0] axis_data_o,
    output logic             axis_valid_o,
    output logic             axis_last_o,
    input  logic             axis_ready_i
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    localparam bit HAS_LAST_B  = (HAS_LAST == "true");
    localparam bit MSB_FIRST_B = (MSB_FIRST == "true");

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    generate
        if ((RATIO < 2) || ((IN_W % OUT_W) != 0)) begin : g_bad_ratio
            $error("fifo_axis_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    logic [0:0]       state_q;
    logic [IN_W-1:0]  buf_q;
    logic             last_q;
    logic [IDX_W-1:0] idx_q;

    logic             full_q;
    logic             on_last_slice;
    logic             out_fire;
    logic             drain;
    logic             in_fire;
    logic             last_in;
    logic [IDX_W-1:0] sel;
    logic [OUT_W-1:0] slices [RATIO];

    assign full_q        = (state_q == ST_ACTIVE);
    assign on_last_slice = (idx_q == LAST_IDX);
    assign out_fire      = full_q & axis_ready_i;
    assign drain         = out_fire & on_last_slice;

    // Ready is combinational from axis_ready_i so a drain and a reload can
    // share one edge; it is held low while reset is asserted.
    assign axis_ready_o = rst_n & (~full_q | drain);
    assign in_fire      = axis_valid_i & axis_ready_o;

    // The last flag is only kept when it is propagated.
    assign last_in = HAS_LAST_B & axis_last_i;

    always_comb begin
        for (int unsigned i = 0; i < RATIO; i++) begin
            slices[i] = buf_q[i*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        sel = idx_q;
        if (MSB_FIRST_B) begin
            sel = LAST_IDX - idx_q;
        end
    end

    assign axis_valid_o = full_q;
    assign axis_data_o  = full_q ? slices[sel] : '0;
    assign axis_last_o  = full_q & last_q & on_last_slice;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        buf_q   <= axis_data_i;
                        last_q  <= last_in;
                        idx_q   <= '0;
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (out_fire) begin
                        if (!on_last_slice) begin
                            idx_q <= idx_q + 1'b1;
                        end else if (in_fire) begin
                            buf_q  <= axis_data_i;
                            last_q <= last_in;
                            idx_q  <= '0;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_axis_downsizer.sv
module tb_fifo_axis_downsizer;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int RATIO = IN_W / OUT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // DUT A: last propagated, LSB slice first
    logic [IN_W-1:0]  a_data_i = '0;
    logic             a_valid_i = 1'b0;
    logic             a_last_i = 1'b0;
    logic             a_ready_o;
    logic [OUT_W-1:0] a_data_o;
    logic             a_valid_o;
    logic             a_last_o;
    logic             a_ready_i = 1'b1;

    // DUT B: last ignored, MSB slice first
    logic [IN_W-1:0]  b_data_i = '0;
    logic             b_valid_i = 1'b0;
    logic             b_last_i = 1'b0;
    logic             b_ready_o;
    logic [OUT_W-1:0] b_data_o;
    logic             b_valid_o;
    logic             b_last_o;
    logic             b_ready_i = 1'b1;

    fifo_axis_downsizer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .HAS_LAST("true"), .MSB_FIRST("false")
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .axis_data_i(a_data_i), .axis_valid_i(a_valid_i), .axis_last_i(a_last_i),
        .axis_ready_o(a_ready_o),
        .axis_data_o(a_data_o), .axis_valid_o(a_valid_o), .axis_last_o(a_last_o),
        .axis_ready_i(a_ready_i)
    );

    fifo_axis_downsizer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .HAS_LAST("false"), .MSB_FIRST("true")
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .axis_data_i(b_data_i), .axis_valid_i(b_valid_i), .axis_last_i(b_last_i),
        .axis_ready_o(b_ready_o),
        .axis_data_o(b_data_o), .axis_valid_o(b_valid_o), .axis_last_o(b_last_o),
        .axis_ready_i(b_ready_i)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard for DUT A: {last, data}
    logic [OUT_W:0] exp_a [$];
    logic [OUT_W:0] obs_a [$];
    int             stall_bad = 0;
    logic           prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_d = '0;
    logic           prev_l = 1'b0;

    // Sampled mid-cycle: handshakes seen here are the ones the next rising
    // edge will complete.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (a_valid_o !== 1'b1 || a_data_o !== prev_d || a_last_o !== prev_l))
                stall_bad <= stall_bad + 1;
            if (a_valid_i && a_ready_o) begin
                for (int i = 0; i < RATIO; i++)
                    exp_a.push_back({a_last_i && (i == RATIO - 1), a_data_i[i*OUT_W +: OUT_W]});
            end
            if (a_valid_o && a_ready_i)
                obs_a.push_back({a_last_o, a_data_o});
            prev_stall <= a_valid_o && !a_ready_i;
            prev_d     <= a_data_o;
            prev_l     <= a_last_o;
        end
    end

    function automatic logic [IN_W-1:0] rand_wide();
        logic [IN_W-1:0] v;
        for (int w = 0; w < IN_W / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [IN_W-1:0] byte_slices(input int base, input int step);
        logic [IN_W-1:0] v;
        for (int k = 0; k < RATIO; k++) v[k*OUT_W +: OUT_W] = {8{8'(base + step * k)}};
        return v;
    endfunction

    task automatic test_reset();
        #1;
        tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b want=0", a_valid_o); end
        tests++; if (a_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b want=0", a_ready_o); end
        tests++; if (a_data_o !== '0) begin fails++; $display("FAIL rst_data got=%h want=0", a_data_o); end
        tests++; if (a_last_o !== 1'b0) begin fails++; $display("FAIL rst_last got=%b want=0", a_last_o); end
        tests++; if (b_ready_o !== 1'b0 || b_valid_o !== 1'b0) begin fails++; $display("FAIL rst_b got=%b%b want=00", b_ready_o, b_valid_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        tests++; if (a_ready_o !== 1'b1) begin fails++; $display("FAIL rel_ready got=%b want=1", a_ready_o); end
        tests++; if (b_ready_o !== 1'b1) begin fails++; $display("FAIL rel_ready_b got=%b want=1", b_ready_o); end
        tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL rel_valid got=%b want=0", a_valid_o); end
    endtask

    task automatic test_single_beat();
        logic [OUT_W:0] got, want;
        @(posedge clk); #1;
        a_data_i = byte_slices(0, 1); a_last_i = 1'b1; a_valid_i = 1'b1; a_ready_i = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b0; a_last_i = 1'b0;
        for (int c = 0; c < RATIO; c++) begin
            @(negedge clk); #1;
            tests++; if (a_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid[%0d] got=%b want=1", c, a_valid_o); end
            tests++; if (a_data_o !== {8{8'(c)}}) begin fails++; $display("FAIL single_data[%0d] got=%h want=%h", c, a_data_o, {8{8'(c)}}); end
            tests++; if (a_last_o !== (c == RATIO - 1)) begin fails++; $display("FAIL single_last[%0d] got=%b want=%b", c, a_last_o, c == RATIO - 1); end
            tests++; if (a_ready_o !== (c == RATIO - 1)) begin fails++; $display("FAIL single_ready[%0d] got=%b want=%b", c, a_ready_o, c == RATIO - 1); end
        end
        tests++; if (obs_a.size() != RATIO) begin fails++; $display("FAIL single_count got=%0d want=%0d", obs_a.size(), RATIO); end
        while (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (exp_a.size() == 0) begin fails++; $display("FAIL single_sb got=%h want=<none>", got); end
            else begin
                want = exp_a.pop_front();
                if (got !== want) begin fails++; $display("FAIL single_sb got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_drain_idle();
        logic [OUT_W:0] got, want;
        @(negedge clk); #1;
        tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL idle_valid got=%b want=0", a_valid_o); end
        tests++; if (a_data_o !== '0) begin fails++; $display("FAIL idle_data got=%h want=0", a_data_o); end
        tests++; if (a_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready got=%b want=1", a_ready_o); end
        repeat (4) @(posedge clk);
        #1;
        a_data_i = byte_slices(8'h40, 1); a_last_i = 1'b0; a_valid_i = 1'b1;
        @(negedge clk); #1;
        tests++; if (a_ready_o !== 1'b1) begin fails++; $display("FAIL late_ready got=%b want=1", a_ready_o); end
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        @(negedge clk); #1;
        tests++; if (a_valid_o !== 1'b1 || a_data_o !== {8{8'h40}}) begin
            fails++; $display("FAIL late_first got=%b/%h want=1/%h", a_valid_o, a_data_o, {8{8'h40}});
        end
        repeat (RATIO) @(negedge clk);
        #1;
        while (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (exp_a.size() == 0) begin fails++; $display("FAIL idle_sb got=%h want=<none>", got); end
            else begin
                want = exp_a.pop_front();
                if (got !== want) begin fails++; $display("FAIL idle_sb got=%h want=%h", got, want); end
            end
        end
        tests++; if (exp_a.size() != 0) begin fails++; $display("FAIL idle_left got=%0d want=0", exp_a.size()); end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W:0] got, want;
        int  j = 0;
        int  k = 0;
        bit  acc;
        bit  started = 1'b0;
        a_ready_i = 1'b1;
        @(posedge clk); #1;
        a_data_i = rand_wide(); a_last_i = 1'b0; a_valid_i = 1'b1;
        for (int cyc = 0; cyc < 60 && k <= 4 * RATIO; cyc++) begin
            @(negedge clk); #1;
            acc = a_valid_i && a_ready_o;
            if (a_valid_o) started = 1'b1;
            if (started) begin
                if (k < 4 * RATIO) begin
                    tests++; if (a_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_gap[%0d] got=%b want=1", k, a_valid_o); end
                    tests++; if (a_ready_o !== ((k % RATIO) == RATIO - 1)) begin
                        fails++; $display("FAIL b2b_ready[%0d] got=%b want=%b", k, a_ready_o, (k % RATIO) == RATIO - 1);
                    end
                end else begin
                    tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_end got=%b want=0", a_valid_o); end
                end
                k++;
            end
            @(posedge clk); #1;
            if (acc) begin
                j++;
                if (j < 4) begin a_data_i = rand_wide(); a_last_i = (j == 3); end
                else begin a_valid_i = 1'b0; a_last_i = 1'b0; end
            end
        end
        tests++; if (k != 4 * RATIO + 1) begin fails++; $display("FAIL b2b_timeout got=%0d want=%0d", k, 4 * RATIO + 1); end
        while (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (exp_a.size() == 0) begin fails++; $display("FAIL b2b_sb got=%h want=<none>", got); end
            else begin
                want = exp_a.pop_front();
                if (got !== want) begin fails++; $display("FAIL b2b_sb got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_random_stall();
        logic [OUT_W:0] got, want;
        int  sent = 0;
        int  compared = 0;
        int  bad = 0;
        bit  acc = 1'b0;
        bit  done = 1'b0;
        a_valid_i = 1'b0;
        for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
            @(posedge clk); #1;
            if (acc || !a_valid_i) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    a_data_i  = rand_wide();
                    a_last_i  = 1'($urandom_range(0, 1));
                    a_valid_i = 1'b1;
                    sent++;
                end else begin
                    a_valid_i = 1'b0;
                end
            end
            a_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            acc = a_valid_i && a_ready_o;
            while (obs_a.size() > 0) begin
                got = obs_a.pop_front();
                compared++;
                if (exp_a.size() == 0) begin
                    bad++;
                    if (bad < 10) $display("FAIL rand_sb got=%h want=<none>", got);
                end else begin
                    want = exp_a.pop_front();
                    if (got !== want) begin
                        bad++;
                        if (bad < 10) $display("FAIL rand_sb[%0d] got=%h want=%h", compared, got, want);
                    end
                end
            end
            done = (sent == 1000) && !a_valid_i && !a_valid_o && (exp_a.size() == 0);
        end
        a_ready_i = 1'b1;
        a_valid_i = 1'b0;
        tests++; if (!done) begin fails++; $display("FAIL rand_timeout got=sent %0d want=1000 drained", sent); end
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_data got=%0d bad want=0", bad); end
        tests++; if (compared != 1000 * RATIO) begin fails++; $display("FAIL rand_count got=%0d want=%0d", compared, 1000 * RATIO); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL rand_stall_stable got=%0d want=0", stall_bad); end
    endtask

    task automatic test_msb_first();
        @(posedge clk); #1;
        b_data_i = byte_slices(1, 1); b_last_i = 1'b1; b_valid_i = 1'b1; b_ready_i = 1'b1;
        @(posedge clk); #1;
        b_valid_i = 1'b0;
        for (int c = 0; c < RATIO; c++) begin
            @(negedge clk); #1;
            tests++; if (b_valid_o !== 1'b1 || b_data_o !== {8{8'(RATIO - c)}}) begin
                fails++; $display("FAIL msb_data[%0d] got=%b/%h want=1/%h", c, b_valid_o, b_data_o, {8{8'(RATIO - c)}});
            end
            tests++; if (b_last_o !== 1'b0) begin fails++; $display("FAIL msb_last[%0d] got=%b want=0", c, b_last_o); end
        end
        @(negedge clk); #1;
        tests++; if (b_valid_o !== 1'b0) begin fails++; $display("FAIL msb_end got=%b want=0", b_valid_o); end
        b_last_i = 1'b0;
    endtask

    task automatic test_reset_mid_beat();
        logic [OUT_W:0] got, want;
        @(posedge clk); #1;
        a_data_i = byte_slices(8'h10, 1); a_last_i = 1'b1; a_valid_i = 1'b1; a_ready_i = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b0; a_last_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b want=0", a_valid_o); end
        tests++; if (a_data_o !== '0) begin fails++; $display("FAIL mid_rst_data got=%h want=0", a_data_o); end
        tests++; if (a_last_o !== 1'b0 || a_ready_o !== 1'b0) begin fails++; $display("FAIL mid_rst_ctl got=%b%b want=00", a_last_o, a_ready_o); end
        tests++; if (obs_a.size() != 3) begin fails++; $display("FAIL mid_rst_sent got=%0d want=3", obs_a.size()); end
        while (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (exp_a.size() == 0) begin fails++; $display("FAIL mid_rst_sb got=%h want=<none>", got); end
            else begin
                want = exp_a.pop_front();
                if (got !== want) begin fails++; $display("FAIL mid_rst_sb got=%h want=%h", got, want); end
            end
        end
        exp_a.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        tests++; if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
            fails++; $display("FAIL post_rst got=%b%b want=01", a_valid_o, a_ready_o);
        end
        @(posedge clk); #1;
        a_data_i = byte_slices(8'h20, 1); a_last_i = 1'b0; a_valid_i = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        for (int c = 0; c < RATIO; c++) begin
            @(negedge clk); #1;
            tests++; if (a_valid_o !== 1'b1 || a_data_o !== {8{8'(8'h20 + c)}}) begin
                fails++; $display("FAIL post_rst_data[%0d] got=%b/%h want=1/%h", c, a_valid_o, a_data_o, {8{8'(8'h20 + c)}});
            end
        end
        while (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (exp_a.size() == 0) begin fails++; $display("FAIL post_rst_sb got=%h want=<none>", got); end
            else begin
                want = exp_a.pop_front();
                if (got !== want) begin fails++; $display("FAIL post_rst_sb got=%h want=%h", got, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_drain_idle();
        test_back_to_back();
        test_random_stall();
        test_msb_first();
        test_reset_mid_beat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
